// File: rtl/joybus_poll_scheduler.sv
// Time-multiplexes one joybus transceiver over the four controller ports, one command per enabled channel.
// Optional JOYBUS_SCHED_RETRY_EN: retry a channel once after a timeout or transceiver error.
module joybus_poll_scheduler #(
   parameter int unsigned RX_LEN  = 4,
   parameter int unsigned TIMEOUT = 2048,
   parameter int unsigned TO_W    = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] ch_enable,
   input  logic [7:0] cmd_byte,
   output logic       busy,
   output logic       done,
   output logic [7:0] ch_status,
   output logic       xcvr_req,
   output logic [1:0] xcvr_sel,
   output logic [7:0] xcvr_cmd,
   input  logic       xcvr_ack,
   input  logic       xcvr_rx_valid,
   input  logic [7:0] xcvr_rx_data,
   input  logic       xcvr_done,
   input  logic       xcvr_err,
   output logic       xcvr_abort,
   output logic       res_we,
   output logic [4:0] res_addr,
   output logic [7:0] res_data
);

   typedef enum logic [2:0] {IDLE, SELECT, REQ, WAIT, NEXT, FINISH} state_t;

   state_t          state;
   logic [3:0]      en_q;
   logic [7:0]      cmd_q;
   logic [1:0]      cur;
   logic [3:0]      byte_idx;
   logic [TO_W-1:0] to_cnt;

   logic            take;
   logic [3:0]      rx_count;
   logic [1:0]      done_status;
   logic [2:0]      st_idx;

`ifdef JOYBUS_SCHED_RETRY_EN
   logic            retry;
   logic            retry_now;
`endif

   // A byte arriving with xcvr_done is counted before the short-reply decision.
   always_comb begin
      take     = xcvr_rx_valid && (byte_idx < 4'(RX_LEN));
      rx_count = byte_idx + (take ? 4'd1 : 4'd0);
      st_idx   = {cur, 1'b0};
      if (xcvr_err)
         done_status = 2'b10;
      else if (rx_count < 4'(RX_LEN))
         done_status = 2'b11;
      else
         done_status = 2'b00;
`ifdef JOYBUS_SCHED_RETRY_EN
      retry_now = !retry && en_q[cur] &&
                  ((ch_status[st_idx +: 2] == 2'b01) || (ch_status[st_idx +: 2] == 2'b10));
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         ch_status  <= 8'h55;
         xcvr_req   <= 1'b0;
         xcvr_sel   <= '0;
         xcvr_cmd   <= '0;
         xcvr_abort <= 1'b0;
         res_we     <= 1'b0;
         res_addr   <= '0;
         res_data   <= '0;
         en_q       <= '0;
         cmd_q      <= '0;
         cur        <= '0;
         byte_idx   <= '0;
         to_cnt     <= '0;
`ifdef JOYBUS_SCHED_RETRY_EN
         retry      <= 1'b0;
`endif
      end else begin
         done       <= 1'b0;
         xcvr_abort <= 1'b0;
         res_we     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  en_q  <= ch_enable;
                  cmd_q <= cmd_byte;
                  cur   <= '0;
                  busy  <= 1'b1;
                  state <= SELECT;
`ifdef JOYBUS_SCHED_RETRY_EN
                  retry <= 1'b0;
`endif
               end
            end
            SELECT: begin
               if (en_q[cur]) begin
                  xcvr_req <= 1'b1;
                  xcvr_sel <= cur;
                  xcvr_cmd <= cmd_q;
                  state    <= REQ;
               end else begin
                  ch_status[st_idx +: 2] <= 2'b01;
                  state                  <= NEXT;
               end
            end
            REQ: begin
               if (xcvr_ack) begin
                  xcvr_req <= 1'b0;
                  byte_idx <= '0;
                  to_cnt   <= '0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               to_cnt <= to_cnt + TO_W'(1);
               if (take) begin
                  res_we   <= 1'b1;
                  res_addr <= {cur, byte_idx[2:0]};
                  res_data <= xcvr_rx_data;
                  byte_idx <= byte_idx + 4'd1;
               end
               if (xcvr_done) begin
                  ch_status[st_idx +: 2] <= done_status;
                  state                  <= NEXT;
               end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  ch_status[st_idx +: 2] <= 2'b01;
                  xcvr_abort             <= 1'b1;
                  state                  <= NEXT;
               end
            end
            NEXT: begin
`ifdef JOYBUS_SCHED_RETRY_EN
               if (retry_now) begin
                  retry    <= 1'b1;
                  xcvr_req <= 1'b1;
                  state    <= REQ;
               end else
`endif
               if (cur == 2'd3) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end else begin
                  cur   <= cur + 2'd1;
                  state <= SELECT;
`ifdef JOYBUS_SCHED_RETRY_EN
                  retry <= 1'b0;
`endif
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_joybus_poll_scheduler.sv
// Self-checking bench for joybus_poll_scheduler: behavioural transceiver plus a result-RAM scoreboard.
module tb_joybus_poll_scheduler;

   localparam int unsigned RX_LEN  = 4;
   localparam int unsigned TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] ch_enable;
   logic [7:0] cmd_byte;
   logic       busy;
   logic       done;
   logic [7:0] ch_status;
   logic       xcvr_req;
   logic [1:0] xcvr_sel;
   logic [7:0] xcvr_cmd;
   logic       xcvr_ack;
   logic       xcvr_rx_valid;
   logic [7:0] xcvr_rx_data;
   logic       xcvr_done;
   logic       xcvr_err;
   logic       xcvr_abort;
   logic       res_we;
   logic [4:0] res_addr;
   logic [7:0] res_data;

   joybus_poll_scheduler #(
      .RX_LEN (RX_LEN),
      .TIMEOUT(TIMEOUT),
      .TO_W   (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .ch_enable    (ch_enable),
      .cmd_byte     (cmd_byte),
      .busy         (busy),
      .done         (done),
      .ch_status    (ch_status),
      .xcvr_req     (xcvr_req),
      .xcvr_sel     (xcvr_sel),
      .xcvr_cmd     (xcvr_cmd),
      .xcvr_ack     (xcvr_ack),
      .xcvr_rx_valid(xcvr_rx_valid),
      .xcvr_rx_data (xcvr_rx_data),
      .xcvr_done    (xcvr_done),
      .xcvr_err     (xcvr_err),
      .xcvr_abort   (xcvr_abort),
      .res_we       (res_we),
      .res_addr     (res_addr),
      .res_data     (res_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-channel transceiver behaviour for the current poll
   int         nbytes [4];
   int         hang_n [4];
   bit         err_f  [4];
   bit         coinc  [4];
   logic [7:0] pat    [4][8];
   int         attempt[4];
   int         req_cnt[4];
   logic [7:0] cur_cmd;
   int         done_cnt;
   int         abort_cnt;
   int         ack_edge;
   logic [12:0] sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] outcome(input int ch, input int att);
      if (att < hang_n[ch]) return 2'b01;
      if (err_f[ch]) return 2'b10;
      if (nbytes[ch] < int'(RX_LEN)) return 2'b11;
      return 2'b00;
   endfunction

   task automatic set_normal();
      for (int c = 0; c < 4; c++) begin
         nbytes[c] = 4;
         hang_n[c] = 0;
         err_f[c]  = 1'b0;
         coinc[c]  = 1'b0;
         pat[c][0] = 8'h10;
         pat[c][1] = 8'h30;
         pat[c][2] = 8'h05;
         pat[c][3] = 8'h04;
         for (int i = 4; i < 8; i++) pat[c][i] = 8'($urandom);
      end
   endtask

   // One transceiver transaction, started when the model sees xcvr_req at a falling edge.
   task automatic serve(input int ch);
      int att;
      int k;
      int idx;
      att = attempt[ch];
      attempt[ch]++;
      req_cnt[ch]++;
      check("xcvr_cmd", 32'(xcvr_cmd), 32'(cur_cmd));
      xcvr_ack = 1'b1;
      ack_edge = cyc + 1;
      @(negedge clk);
      xcvr_ack = 1'b0;
      if (reset) return;
      if (att < hang_n[ch]) begin
         k = 0;
         while (!xcvr_abort && !reset && k < int'(TIMEOUT) + 10) begin
            @(negedge clk);
            k++;
         end
         if (reset) return;
         check("abort_seen", 32'(xcvr_abort), 32'd1);
         check("abort_latency", 32'(cyc - ack_edge), TIMEOUT);
      end else begin
         idx = 0;
         for (int i = 0; i < nbytes[ch]; i++) begin
            xcvr_rx_valid = 1'b1;
            xcvr_rx_data  = pat[ch][i];
            if (i == nbytes[ch] - 1 && coinc[ch]) begin
               xcvr_done = 1'b1;
               xcvr_err  = err_f[ch];
            end
            if (idx < int'(RX_LEN)) sb.push_back({2'(ch), 3'(idx), pat[ch][i]});
            idx++;
            @(negedge clk);
            xcvr_rx_valid = 1'b0;
            xcvr_done     = 1'b0;
            xcvr_err      = 1'b0;
         end
         if (!coinc[ch] || nbytes[ch] == 0) begin
            xcvr_done = 1'b1;
            xcvr_err  = err_f[ch];
            @(negedge clk);
            xcvr_done = 1'b0;
            xcvr_err  = 1'b0;
         end
      end
   endtask

   initial begin
      xcvr_ack      = 1'b0;
      xcvr_rx_valid = 1'b0;
      xcvr_rx_data  = '0;
      xcvr_done     = 1'b0;
      xcvr_err      = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && xcvr_req) serve(int'(xcvr_sel));
      end
   end

   // Output monitor: pulse counters and result-RAM scoreboard
   initial begin
      logic [12:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (done) done_cnt++;
            if (xcvr_abort) abort_cnt++;
            if (res_we) begin
               e = (sb.size() > 0) ? sb.pop_front() : 13'h1FFF;
               check("res_write", 32'({res_addr, res_data}), 32'(e));
            end
         end
      end
   end

   task automatic run_poll(input string name, input logic [3:0] en, input logic [7:0] cmd,
                           input bit extra_start, input int exp_cycles);
      logic [7:0] exp_st;
      logic [7:0] st_at_done;
      int         exp_req[4];
      int         exp_ab;
      int         att;
      int         n;
      logic [1:0] s;
      exp_ab = 0;
      for (int c = 0; c < 4; c++) begin
         attempt[c] = 0;
         req_cnt[c] = 0;
         exp_req[c] = 0;
         if (!en[c]) begin
            s = 2'b01;
         end else begin
            s   = outcome(c, 0);
            att = 1;
`ifdef JOYBUS_SCHED_RETRY_EN
            if (s == 2'b01 || s == 2'b10) begin
               s   = outcome(c, 1);
               att = 2;
            end
`endif
            exp_req[c] = att;
            for (int a = 0; a < att; a++) if (a < hang_n[c]) exp_ab++;
         end
         exp_st[2*c +: 2] = s;
      end
      done_cnt  = 0;
      abort_cnt = 0;
      cur_cmd   = cmd;
      @(negedge clk);
      ch_enable = en;
      cmd_byte  = cmd;
      start     = 1'b1;
      n         = 1;
      while (!done && n < 4000) begin
         @(negedge clk);
         start = extra_start && (n == 5);
         n++;
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(done), 32'd1);
      if (exp_cycles > 0) check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_status"}, 32'(ch_status), 32'(exp_st));
      st_at_done = ch_status;
      repeat (4) @(negedge clk);
      check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({name, "_aborts"}, 32'(abort_cnt), 32'(exp_ab));
      check({name, "_status_hold"}, 32'(ch_status), 32'(st_at_done));
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      for (int c = 0; c < 4; c++)
         check($sformatf("%s_req_ch%0d", name, c), 32'(req_cnt[c]), 32'(exp_req[c]));
      sb.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      reset     = 1'b1;
      start     = 1'b0;
      ch_enable = '0;
      cmd_byte  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_status", 32'(ch_status), 32'h55);
      check("rst_req", 32'(xcvr_req), 32'd0);
      check("rst_res_we", 32'(res_we), 32'd0);
      check("rst_outs", 32'({xcvr_sel, xcvr_cmd, res_addr, res_data, xcvr_abort}), 32'd0);
      reset = 1'b0;

      set_normal();
      run_poll("all_on", 4'hF, 8'h01, 1'b0, 0);

      set_normal();
      run_poll("all_off", 4'h0, 8'h01, 1'b0, 10);

      set_normal();
      hang_n[2] = 2;
      run_poll("ch2_timeout", 4'hF, 8'h01, 1'b0, 0);

      set_normal();
      for (int c = 0; c < 4; c++) for (int i = 0; i < 8; i++) pat[c][i] = 8'($urandom);
      nbytes[0] = 2;
      nbytes[1] = 6;
      coinc[2]  = 1'b1;
      nbytes[3] = 1;
      err_f[3]  = 1'b1;
      run_poll("reply_len", 4'hF, 8'h41, 1'b0, 0);

      set_normal();
      run_poll("start_busy", 4'hF, 8'h01, 1'b1, 0);

      // Reset while channel 0 is waiting on a reply that never completes
      set_normal();
      hang_n[0] = 2;
      for (int c = 0; c < 4; c++) begin
         attempt[c] = 0;
         req_cnt[c] = 0;
      end
      cur_cmd = 8'h01;
      @(negedge clk);
      ch_enable = 4'hF;
      cmd_byte  = 8'h01;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (req_cnt[0] == 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rst_wait_req", 32'(req_cnt[0]), 32'd1);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_status", 32'(ch_status), 32'h55);
      check("midrst_req", 32'(xcvr_req), 32'd0);
      check("midrst_abort", 32'(xcvr_abort), 32'd0);
      reset = 1'b0;
      sb.delete();

      set_normal();
      run_poll("after_reset", 4'hF, 8'h01, 1'b0, 0);

      set_normal();
      hang_n[1] = 1;
      run_poll("retry", 4'hF, 8'h01, 1'b0, 0);

      set_normal();
      nbytes[0] = 0;
      run_poll("sparse", 4'b0101, 8'hFF, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
